// File: rtl/usb3_ep0_ctrl_xfer_if.sv
// EP0 control-transfer bus bundle: SETUP input, EP0 IN/OUT buffer ports, TX packetiser stream.
// master = the transfer driver, slave = its surroundings (link RX/TX and the EP0 responder).
interface usb3_ep0_ctrl_xfer_if;
    logic        setup_valid;
    logic [63:0] setup_data;
    logic        setup_ready;
    logic [8:0]  buf_in_addr;
    logic [31:0] buf_in_data;
    logic        buf_in_wren;
    logic        buf_in_ready;
    logic        buf_in_commit;
    logic [10:0] buf_in_commit_len;
    logic        buf_in_commit_ack;
    logic [8:0]  buf_out_addr;
    logic [31:0] buf_out_q;
    logic [10:0] buf_out_len;
    logic        buf_out_hasdata;
    logic        buf_out_arm;
    logic        buf_out_arm_ack;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] tx_data;
    logic [3:0]  tx_be;
    logic        tx_last;
    logic        tx_zlp;
    logic        err_timeout;

    modport master (
        input  setup_valid, setup_data, buf_in_ready, buf_in_commit_ack,
               buf_out_q, buf_out_len, buf_out_hasdata, buf_out_arm_ack, tx_ready,
        output setup_ready, buf_in_addr, buf_in_data, buf_in_wren, buf_in_commit,
               buf_in_commit_len, buf_out_addr, buf_out_arm, tx_valid, tx_data,
               tx_be, tx_last, tx_zlp, err_timeout
    );

    modport slave (
        output setup_valid, setup_data, buf_in_ready, buf_in_commit_ack,
               buf_out_q, buf_out_len, buf_out_hasdata, buf_out_arm_ack, tx_ready,
        input  setup_ready, buf_in_addr, buf_in_data, buf_in_wren, buf_in_commit,
               buf_in_commit_len, buf_out_addr, buf_out_arm, tx_valid, tx_data,
               tx_be, tx_last, tx_zlp, err_timeout
    );
endinterface

// File: rtl/usb3_ep0_ctrl_xfer.sv
// EP0 control-transfer driver: SETUP -> EP0 IN buffer + commit, EP0 OUT response -> TX beats, re-arm.
// Optional handshake watchdog enabled by defining USB3_EP0_CTRL_TIMEOUT_EN.
module usb3_ep0_ctrl_xfer #(
    parameter int RD_LAT  = 2,
    parameter int MAX_PKT = 512
`ifdef USB3_EP0_CTRL_TIMEOUT_EN
    , parameter int TIMEOUT_CYC = 4096
`endif
) (
    input logic                  local_clk,
    input logic                  reset_n,
    usb3_ep0_ctrl_xfer_if.master bus
);
    typedef enum logic [3:0] {
        ST_IDLE, ST_WR0, ST_WR1, ST_COMMIT, ST_WAIT_ACKLO, ST_WAIT_DATA,
        ST_ZLP, ST_RD, ST_TX, ST_ARM, ST_ARM_LO
    } state_t;

    localparam logic [11:0] MAX_PKT_B = 12'(MAX_PKT);

    state_t          state;
    logic [31:0]     setup_lo;
    logic [10:0]     rem;
    logic [10:0]     pkt_cnt;
    logic [RD_LAT:0] vld_pipe;
    logic [8:0]      in_addr;
    logic [8:0]      out_addr;
    logic [31:0]     in_data;
    logic [31:0]     tx_data;
    logic [10:0]     commit_len;
    logic [3:0]      tx_be;
    logic            in_wren, commit, arm, tx_valid, tx_last, tx_zlp;
    logic [3:0]      beat_be;
    logic            beat_last;

    // Partial final dword keeps its bytes at the MSB end.
    always_comb begin
        beat_be = 4'hF;
        if (rem == 11'd1)      beat_be = 4'h8;
        else if (rem == 11'd2) beat_be = 4'hC;
        else if (rem == 11'd3) beat_be = 4'hE;
        beat_last = (rem <= 11'd4) || (({1'b0, pkt_cnt} + 12'd4) >= MAX_PKT_B);
    end

`ifdef USB3_EP0_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
    logic [TW-1:0] to_cnt;
    logic          err_to;
    logic          timed;
    assign timed = (state == ST_COMMIT) || (state == ST_WAIT_DATA) || (state == ST_ARM);
`endif

    always_ff @(posedge local_clk) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            setup_lo   <= '0;
            rem        <= '0;
            pkt_cnt    <= '0;
            vld_pipe   <= '0;
            in_addr    <= '0;
            out_addr   <= '0;
            in_data    <= '0;
            tx_data    <= '0;
            commit_len <= '0;
            tx_be      <= '0;
            in_wren    <= 1'b0;
            commit     <= 1'b0;
            arm        <= 1'b0;
            tx_valid   <= 1'b0;
            tx_last    <= 1'b0;
            tx_zlp     <= 1'b0;
`ifdef USB3_EP0_CTRL_TIMEOUT_EN
            to_cnt     <= '0;
            err_to     <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: if (bus.setup_valid && bus.buf_in_ready) begin
                    setup_lo <= bus.setup_data[31:0];
                    in_addr  <= 9'd0;
                    in_data  <= bus.setup_data[63:32];
                    in_wren  <= 1'b1;
                    state    <= ST_WR0;
                end
                ST_WR0: begin
                    in_addr <= 9'd1;
                    in_data <= setup_lo;
                    state   <= ST_WR1;
                end
                ST_WR1: begin
                    in_wren    <= 1'b0;
                    commit     <= 1'b1;
                    commit_len <= 11'd8;
                    state      <= ST_COMMIT;
                end
                ST_COMMIT: if (bus.buf_in_commit_ack) begin
                    commit     <= 1'b0;
                    commit_len <= '0;
                    state      <= ST_WAIT_ACKLO;
                end
                ST_WAIT_ACKLO: if (!bus.buf_in_commit_ack) state <= ST_WAIT_DATA;
                ST_WAIT_DATA: if (bus.buf_out_hasdata) begin
                    rem      <= bus.buf_out_len;
                    out_addr <= 9'd0;
                    pkt_cnt  <= '0;
                    if (bus.buf_out_len == 11'd0) begin
                        tx_valid <= 1'b1;
                        tx_zlp   <= 1'b1;
                        tx_last  <= 1'b1;
                        tx_be    <= 4'h0;
                        state    <= ST_ZLP;
                    end else begin
                        vld_pipe    <= '0;
                        vld_pipe[0] <= 1'b1;
                        state       <= ST_RD;
                    end
                end
                ST_ZLP: if (bus.tx_ready) begin
                    tx_valid <= 1'b0;
                    tx_zlp   <= 1'b0;
                    tx_last  <= 1'b0;
                    arm      <= 1'b1;
                    state    <= ST_ARM;
                end
                // One read in flight; the token reaching the top bit marks buf_out_q valid.
                ST_RD: begin
                    vld_pipe <= vld_pipe << 1;
                    if (vld_pipe[RD_LAT]) begin
                        tx_data  <= bus.buf_out_q;
                        tx_be    <= beat_be;
                        tx_last  <= beat_last;
                        tx_valid <= 1'b1;
                        state    <= ST_TX;
                    end
                end
                ST_TX: if (bus.tx_ready) begin
                    tx_valid <= 1'b0;
                    tx_last  <= 1'b0;
                    tx_be    <= 4'h0;
                    out_addr <= out_addr + 9'd1;
                    pkt_cnt  <= tx_last ? 11'd0 : pkt_cnt + 11'd4;
                    if (rem <= 11'd4) begin
                        rem   <= '0;
                        arm   <= 1'b1;
                        state <= ST_ARM;
                    end else begin
                        rem         <= rem - 11'd4;
                        vld_pipe    <= '0;
                        vld_pipe[0] <= 1'b1;
                        state       <= ST_RD;
                    end
                end
                ST_ARM: if (bus.buf_out_arm_ack) begin
                    arm   <= 1'b0;
                    state <= ST_ARM_LO;
                end
                ST_ARM_LO: if (!bus.buf_out_arm_ack && !bus.buf_out_hasdata) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
`ifdef USB3_EP0_CTRL_TIMEOUT_EN
            // Timed waits are never adjacent, so clearing outside them restarts the count per state.
            if (timed) begin
                to_cnt <= to_cnt + 1'b1;
                if (to_cnt == TO_LAST) begin
                    err_to     <= 1'b1;
                    commit     <= 1'b0;
                    commit_len <= '0;
                    arm        <= 1'b0;
                    to_cnt     <= '0;
                    state      <= ST_IDLE;
                end
            end else begin
                to_cnt <= '0;
            end
`endif
        end
    end

    assign bus.setup_ready       = reset_n && (state == ST_IDLE) && bus.buf_in_ready;
    assign bus.buf_in_addr       = in_addr;
    assign bus.buf_in_data       = in_data;
    assign bus.buf_in_wren       = in_wren;
    assign bus.buf_in_commit     = commit;
    assign bus.buf_in_commit_len = commit_len;
    assign bus.buf_out_addr      = out_addr;
    assign bus.buf_out_arm       = arm;
    assign bus.tx_valid          = tx_valid;
    assign bus.tx_data           = tx_data;
    assign bus.tx_be             = tx_be;
    assign bus.tx_last           = tx_last;
    assign bus.tx_zlp            = tx_zlp;
`ifdef USB3_EP0_CTRL_TIMEOUT_EN
    assign bus.err_timeout       = err_to;
`else
    assign bus.err_timeout       = 1'b0;
`endif
endmodule

// File: tb/tb_usb3_ep0_ctrl_xfer.sv
// Directed bench for usb3_ep0_ctrl_xfer: SETUP write/commit, descriptor, ZLP, multi-packet,
// TX stalls, not-ready SETUP and reset mid-transfer, against a 2-cycle latency ROM model.
module tb_usb3_ep0_ctrl_xfer;
    logic local_clk = 1'b0;
    logic reset_n   = 1'b0;
    int   n_cmp     = 0;
    int   n_err     = 0;

    always #5 local_clk = ~local_clk;

    usb3_ep0_ctrl_xfer_if bus ();

    usb3_ep0_ctrl_xfer dut (
        .local_clk (local_clk),
        .reset_n   (reset_n),
        .bus       (bus)
    );

    function automatic logic [31:0] rom(input logic [8:0] a);
        return 32'hC0DE_0000 | {23'd0, a};
    endfunction

    // Response buffer with two register stages from address to data.
    logic [8:0] ra1, ra2;
    always @(posedge local_clk) begin
        ra1 <= bus.buf_out_addr;
        ra2 <= ra1;
    end
    assign bus.buf_out_q = rom(ra2);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge local_clk);
        #1;
    endtask

    // SETUP accept, both IN-buffer writes, commit handshake, then present the response.
    task automatic do_setup(input logic [63:0] sd, input logic [10:0] len);
        bus.setup_data  = sd;
        bus.setup_valid = 1'b1;
        tick();
        bus.setup_valid = 1'b0;
        check("wr0_wren", 64'(bus.buf_in_wren), 64'd1);
        check("wr0_addr", 64'(bus.buf_in_addr), 64'd0);
        check("wr0_data", 64'(bus.buf_in_data), 64'(sd[63:32]));
        check("busy_ready", 64'(bus.setup_ready), 64'd0);
        tick();
        check("wr1_addr", 64'(bus.buf_in_addr), 64'd1);
        check("wr1_data", 64'(bus.buf_in_data), 64'(sd[31:0]));
        tick();
        check("cmt_wren", 64'(bus.buf_in_wren), 64'd0);
        check("cmt_level", 64'(bus.buf_in_commit), 64'd1);
        check("cmt_len", 64'(bus.buf_in_commit_len), 64'd8);
        tick();
        check("cmt_hold", 64'(bus.buf_in_commit), 64'd1);
        bus.buf_in_commit_ack = 1'b1;
        tick();
        check("cmt_drop", 64'(bus.buf_in_commit), 64'd0);
        bus.buf_in_commit_ack = 1'b0;
        tick();
        bus.buf_out_len     = len;
        bus.buf_out_hasdata = 1'b1;
    endtask

    task automatic get_beat(output logic [31:0] d, output logic [3:0] be,
                            output logic last, output logic zlp);
        int w = 0;
        while (!bus.tx_valid && w < 40) begin
            tick();
            w++;
        end
        check("beat_wait", 64'(bus.tx_valid), 64'd1);
        d    = bus.tx_data;
        be   = bus.tx_be;
        last = bus.tx_last;
        zlp  = bus.tx_zlp;
        bus.tx_ready = 1'b1;
        tick();
        bus.tx_ready = 1'b0;
    endtask

    task automatic arm_handshake();
        int w = 0;
        while (!bus.buf_out_arm && w < 40) begin
            tick();
            w++;
        end
        check("arm_set", 64'(bus.buf_out_arm), 64'd1);
        bus.buf_out_hasdata = 1'b0;
        bus.buf_out_arm_ack = 1'b1;
        tick();
        check("arm_drop", 64'(bus.buf_out_arm), 64'd0);
        bus.buf_out_arm_ack = 1'b0;
        tick();
        check("back_idle", 64'(bus.setup_ready), 64'd1);
    endtask

    initial begin
        logic [31:0] d, hd;
        logic [3:0]  be, hb;
        logic        last, zlp, pv, pr;
        logic [3:0]  pat;
        int          nb, w;

        bus.setup_valid       = 1'b0;
        bus.setup_data        = '0;
        bus.buf_in_ready      = 1'b1;
        bus.buf_in_commit_ack = 1'b0;
        bus.buf_out_len       = '0;
        bus.buf_out_hasdata   = 1'b0;
        bus.buf_out_arm_ack   = 1'b0;
        bus.tx_ready          = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_ready", 64'(bus.setup_ready), 64'd0);
        check("rst_txv", 64'(bus.tx_valid), 64'd0);
        check("rst_wren", 64'(bus.buf_in_wren), 64'd0);
        check("rst_commit", 64'(bus.buf_in_commit), 64'd0);
        check("rst_arm", 64'(bus.buf_out_arm), 64'd0);
        check("rst_err", 64'(bus.err_timeout), 64'd0);
        reset_n = 1'b1;
        tick();
        check("idle_ready", 64'(bus.setup_ready), 64'd1);

        // GET_DESCRIPTOR(device), 18-byte response: 4 full beats + 2-byte tail
        do_setup(64'h8006_0001_0000_1200, 11'd18);
        for (int i = 0; i < 5; i++) begin
            get_beat(d, be, last, zlp);
            check("gd_data", 64'(d), 64'(rom(9'(i))));
            check("gd_be", 64'(be), (i == 4) ? 64'hC : 64'hF);
            check("gd_last", 64'(last), (i == 4) ? 64'd1 : 64'd0);
            check("gd_zlp", 64'(zlp), 64'd0);
        end
        arm_handshake();

        // SET_ADDRESS, zero-length status
        do_setup(64'h0005_0700_0000_0000, 11'd0);
        get_beat(d, be, last, zlp);
        check("zlp_flag", 64'(zlp), 64'd1);
        check("zlp_be", 64'(be), 64'h0);
        check("zlp_last", 64'(last), 64'd1);
        arm_handshake();

        // 600-byte config descriptor: 512-byte packet then 88-byte packet
        do_setup(64'h8006_0002_0000_5802, 11'd600);
        for (int i = 0; i < 150; i++) begin
            get_beat(d, be, last, zlp);
            check("cfg_data", 64'(d), 64'(rom(9'(i))));
            check("cfg_last", 64'(last), (i == 127 || i == 149) ? 64'd1 : 64'd0);
            if (i == 127 || i == 149) check("cfg_be", 64'(be), 64'hF);
        end
        arm_handshake();

        // tx_ready pattern 1-0-0-1 over a 16-byte response
        do_setup(64'h8006_0003_0000_1000, 11'd16);
        pat = 4'b1001;
        nb  = 0;
        pv  = 1'b0;
        pr  = 1'b0;
        hd  = '0;
        hb  = '0;
        for (int c = 0; c < 80 && !bus.buf_out_arm; c++) begin
            if (bus.tx_valid) begin
                if (pv && !pr) begin
                    check("stall_data", 64'(bus.tx_data), 64'(hd));
                    check("stall_be", 64'(bus.tx_be), 64'(hb));
                end else begin
                    check("stall_beat", 64'(bus.tx_data), 64'(rom(9'(nb))));
                    nb++;
                end
                hd = bus.tx_data;
                hb = bus.tx_be;
            end
            pv = bus.tx_valid;
            bus.tx_ready = pat[c[1:0]];
            pr = bus.tx_ready;
            tick();
        end
        bus.tx_ready = 1'b0;
        check("stall_count", 64'(nb), 64'd4);
        arm_handshake();

        // SETUP offered while the IN buffer is busy
        bus.buf_in_ready = 1'b0;
        bus.setup_data   = 64'h8006_0001_0000_4000;
        bus.setup_valid  = 1'b1;
        repeat (3) begin
            tick();
            check("nrdy_ready", 64'(bus.setup_ready), 64'd0);
            check("nrdy_wren", 64'(bus.buf_in_wren), 64'd0);
        end
        bus.setup_valid  = 1'b0;
        bus.buf_in_ready = 1'b1;
        tick();

        // Reset while a beat is being offered
        do_setup(64'h8006_0001_0000_2800, 11'd40);
        w = 0;
        while (!bus.tx_valid && w < 40) begin
            tick();
            w++;
        end
        check("mid_txv", 64'(bus.tx_valid), 64'd1);
        reset_n = 1'b0;
        tick();
        check("mid_rst_txv", 64'(bus.tx_valid), 64'd0);
        check("mid_rst_arm", 64'(bus.buf_out_arm), 64'd0);
        bus.buf_out_hasdata = 1'b0;
        reset_n = 1'b1;
        tick();
        check("mid_idle", 64'(bus.setup_ready), 64'd1);
        check("mid_err", 64'(bus.err_timeout), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
